// File: rtl/jtag_driver.sv
`default_nettype none
// ============================================================================
// Module      : jtag_driver
// Description : Command-driven JTAG master: TAP reset, IR/DR scans up to 32
//               bits and idle clocking, with TCK derived from clk_i.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_driver #(
    parameter int unsigned ClkDiv = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [4:0]  cmd_len_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        jtag_tck_o,
    output logic        jtag_tms_o,
    output logic        jtag_tdi_o,
    output logic        jtag_trst_no,
    input  logic        jtag_tdo_i
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;
    localparam logic [1:0] OP_IDLE  = 2'b11;
    localparam logic [7:0] DIV_LAST = 8'(ClkDiv - 1);

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  len_q, len_d;
    logic [31:0] data_q, data_d;
    logic [5:0]  bit_q, bit_d;
    logic [7:0]  div_q, div_d;
    logic        tck_q, tck_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;
    logic        trst_n_q, trst_n_d;
    logic [31:0] cap_q, cap_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [5:0]  bit_nxt;

    function automatic logic is_scan(input logic [1:0] op);
        return (op == OP_IR) || (op == OP_DR);
    endfunction

    function automatic logic [5:0] shift_start(input logic [1:0] op);
        return (op == OP_IR) ? 6'd4 : 6'd3;
    endfunction

    // Index of the final TCK bit of an op: reset 6 bits, idle N, DR N+5, IR N+6
    function automatic logic [5:0] last_bit(input logic [1:0] op, input logic [4:0] len);
        case (op)
            OP_RESET: return 6'd5;
            OP_IDLE:  return {1'b0, len};
            OP_DR:    return {1'b0, len} + 6'd5;
            default:  return {1'b0, len} + 6'd6;
        endcase
    endfunction

    function automatic logic in_shift(input logic [1:0] op, input logic [4:0] len,
                                      input logic [5:0] idx);
        return is_scan(op) && (idx >= shift_start(op))
            && (idx <= shift_start(op) + {1'b0, len});
    endfunction

    function automatic logic [4:0] shift_idx(input logic [1:0] op, input logic [5:0] idx);
        return 5'(idx - shift_start(op));
    endfunction

    // Scans: 1 at SelectDR (and SelectIR), then 1 on the last shift bit and Update
    function automatic logic tms_bit(input logic [1:0] op, input logic [4:0] len,
                                     input logic [5:0] idx);
        case (op)
            OP_RESET: return idx < 6'd5;
            OP_IDLE:  return 1'b0;
            default:  return (idx == 6'd0) || ((op == OP_IR) && (idx == 6'd1))
                          || (idx == shift_start(op) + {1'b0, len})
                          || (idx == shift_start(op) + {1'b0, len} + 6'd1);
        endcase
    endfunction

    function automatic logic tdi_bit(input logic [1:0] op, input logic [4:0] len,
                                     input logic [31:0] data, input logic [5:0] idx);
        return in_shift(op, len, idx) ? data[shift_idx(op, idx)] : 1'b0;
    endfunction

    assign bit_nxt = bit_q + 6'd1;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        len_d       = len_q;
        data_d      = data_q;
        bit_d       = bit_q;
        div_d       = div_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        trst_n_d    = trst_n_q;
        cap_d       = cap_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    state_d  = ST_RUN;
                    op_d     = cmd_op_i;
                    len_d    = cmd_len_i;
                    data_d   = cmd_data_i;
                    bit_d    = 6'd0;
                    div_d    = 8'd0;
                    tck_d    = 1'b0;
                    tms_d    = tms_bit(cmd_op_i, cmd_len_i, 6'd0);
                    tdi_d    = tdi_bit(cmd_op_i, cmd_len_i, cmd_data_i, 6'd0);
                    trst_n_d = (cmd_op_i != OP_RESET);
                    cap_d    = 32'd0;
                end
            end
            ST_INIT, ST_RUN: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = 8'd0;
                    if (!tck_q) begin
                        // Rising TCK: TDO is captured on this same cycle
                        tck_d = 1'b1;
                        if (in_shift(op_q, len_q, bit_q)) begin
                            cap_d[shift_idx(op_q, bit_q)] = jtag_tdo_i;
                        end
                    end else begin
                        tck_d = 1'b0;
                        if (bit_q == last_bit(op_q, len_q)) begin
                            tms_d    = 1'b0;
                            tdi_d    = 1'b0;
                            trst_n_d = 1'b1;
                            if (state_q == ST_INIT) begin
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_DONE;
                                if (is_scan(op_q)) begin
                                    rsp_valid_d = 1'b1;
                                    rsp_data_d  = cap_q;
                                end
                            end
                        end else begin
                            bit_d    = bit_nxt;
                            tms_d    = tms_bit(op_q, len_q, bit_nxt);
                            tdi_d    = tdi_bit(op_q, len_q, data_q, bit_nxt);
                            trst_n_d = !((op_q == OP_RESET) && (bit_nxt < 6'd5));
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset values double as the setup of TAP-reset bit 0 for the INIT sequence
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_INIT;
            op_q        <= OP_RESET;
            len_q       <= 5'd0;
            data_q      <= 32'd0;
            bit_q       <= 6'd0;
            div_q       <= 8'd0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            trst_n_q    <= 1'b0;
            cap_q       <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            len_q       <= len_d;
            data_q      <= data_d;
            bit_q       <= bit_d;
            div_q       <= div_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            trst_n_q    <= trst_n_d;
            cap_q       <= cap_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ready_o  = (state_q == ST_IDLE);
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign jtag_tck_o   = tck_q;
    assign jtag_tms_o   = tms_q;
    assign jtag_tdi_o   = tdi_q;
    assign jtag_trst_no = trst_n_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_driver
// Description : Directed self-checking bench for jtag_driver (ClkDiv = 2).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_jtag_driver;

    localparam int CLK_DIV = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic [1:0]  cmd_op_i = 2'b00;
    logic [4:0]  cmd_len_i = 5'd0;
    logic [31:0] cmd_data_i = 32'd0;
    logic        cmd_ready_o, rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no;
    logic        jtag_tdo_i;

    int tests_run = 0;
    int tests_failed = 0;

    jtag_driver #(.ClkDiv(CLK_DIV)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_len_i(cmd_len_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .jtag_tck_o(jtag_tck_o), .jtag_tms_o(jtag_tms_o), .jtag_tdi_o(jtag_tdi_o),
        .jtag_trst_no(jtag_trst_no), .jtag_tdo_i(jtag_tdo_i)
    );

    always #5 clk_i = ~clk_i;

    // Target model: 0 drives 0, 1 loops TDI, 2 loops TDI through a preset-1 delay, 3 drives 1
    int   tdo_mode = 0;
    int   tck_rises = 0;
    int   dly_base = 0;
    int   dly_len = 0;
    logic dly = 1'b1;

    always @(posedge jtag_tck_o) begin
        if (tck_rises - dly_base < 3) dly <= 1'b1;
        else if (tck_rises - dly_base <= 3 + dly_len) dly <= jtag_tdi_o;
        tck_rises = tck_rises + 1;
    end

    assign jtag_tdo_i = (tdo_mode == 1) ? jtag_tdi_o :
                        (tdo_mode == 2) ? dly : (tdo_mode == 3);

    int          cyc = 0, rises = 0, hi_total = 0, trst_low_total = 0;
    int          valid_total = 0, accept_total = 0;
    logic        tms_rec [0:511];
    logic        tdi_rec [0:511];
    int          rise_cyc [0:511];
    logic        prev_tck = 1'b0;
    logic [31:0] last_rsp = 32'd0;

    always @(negedge clk_i) begin
        if (jtag_tck_o && !prev_tck) begin
            if (rises < 512) begin
                tms_rec[rises]  = jtag_tms_o;
                tdi_rec[rises]  = jtag_tdi_o;
                rise_cyc[rises] = cyc;
            end
            rises = rises + 1;
        end
        if (jtag_tck_o) hi_total = hi_total + 1;
        if (!jtag_trst_no) trst_low_total = trst_low_total + 1;
        if (rsp_valid_o) begin
            valid_total = valid_total + 1;
            last_rsp    = rsp_data_o;
        end
        if (cmd_valid_i && cmd_ready_o) accept_total = accept_total + 1;
        prev_tck = jtag_tck_o;
        cyc      = cyc + 1;
    end

    function automatic logic [63:0] seq_tms(input int base, input int n);
        logic [63:0] s = '0;
        for (int i = 0; i < n && i < 64; i++) s[i] = tms_rec[base + i];
        return s;
    endfunction

    function automatic logic [63:0] seq_tdi(input int base, input int n);
        logic [63:0] s = '0;
        for (int i = 0; i < n && i < 64; i++) s[i] = tdi_rec[base + i];
        return s;
    endfunction

    function automatic int bad_intervals(input int base, input int n);
        int cnt = 0;
        for (int i = 1; i < n; i++)
            if (rise_cyc[base + i] - rise_cyc[base + i - 1] != 2 * CLK_DIV) cnt++;
        return cnt;
    endfunction

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_i); #1;
            if (cmd_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data);
        dly_base    = tck_rises;
        dly_len     = int'(len);
        cmd_op_i    = op;
        cmd_len_i   = len;
        cmd_data_i  = data;
        cmd_valid_i = 1'b1;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        int rb, cb, hb, tb, vb;
        bit ok;
        repeat (3) @(posedge clk_i);
        #1;
        tests_run++; if ({jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no} !== 4'b0100) begin
            tests_failed++; $display("FAIL reset_jtag_pins: got %b want 0100", {jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no}); end
        tests_run++; if ({cmd_ready_o, rsp_valid_o} !== 2'b00) begin
            tests_failed++; $display("FAIL reset_handshake: got %b want 00", {cmd_ready_o, rsp_valid_o}); end
        tests_run++; if (rsp_data_o !== 32'd0) begin
            tests_failed++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data_o); end
        rb = rises; cb = cyc; hb = hi_total; tb = trst_low_total; vb = valid_total;
        rst_ni = 1'b1;
        wait_ready(200, ok);
        tests_run++; if (ok !== 1'b1) begin
            tests_failed++; $display("FAIL init_ready_timeout: got %b want 1", ok); end
        tests_run++; if (rises - rb !== 6) begin
            tests_failed++; $display("FAIL init_bits: got %0d want 6", rises - rb); end
        tests_run++; if (rise_cyc[rb] - cb !== CLK_DIV) begin
            tests_failed++; $display("FAIL init_first_rise: got %0d want %0d", rise_cyc[rb] - cb, CLK_DIV); end
        tests_run++; if (bad_intervals(rb, 6) !== 0) begin
            tests_failed++; $display("FAIL init_tck_period: got %0d bad want 0", bad_intervals(rb, 6)); end
        tests_run++; if (hi_total - hb !== 6 * CLK_DIV) begin
            tests_failed++; $display("FAIL init_tck_high: got %0d want %0d", hi_total - hb, 6 * CLK_DIV); end
        tests_run++; if (seq_tms(rb, 6) !== 64'h1F) begin
            tests_failed++; $display("FAIL init_tms: got %h want 1f", seq_tms(rb, 6)); end
        tests_run++; if (trst_low_total - tb !== 20) begin
            tests_failed++; $display("FAIL init_trst_cycles: got %0d want 20", trst_low_total - tb); end
        tests_run++; if (valid_total - vb !== 0) begin
            tests_failed++; $display("FAIL init_no_rsp: got %0d want 0", valid_total - vb); end
        tests_run++; if ({jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no} !== 4'b0001) begin
            tests_failed++; $display("FAIL idle_jtag_pins: got %b want 0001", {jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no}); end
    endtask

    task automatic test_dr_delay;
        int rb, hb, vb, ab;
        bit ok;
        tdo_mode = 2;
        rb = rises; hb = hi_total; vb = valid_total; ab = accept_total;
        issue(2'b10, 5'd7, 32'h0000_00A5);
        wait_ready(400, ok);
        tests_run++; if (ok !== 1'b1) begin
            tests_failed++; $display("FAIL dr8_timeout: got %b want 1", ok); end
        tests_run++; if (rises - rb !== 13) begin
            tests_failed++; $display("FAIL dr8_bits: got %0d want 13", rises - rb); end
        tests_run++; if (seq_tms(rb, 13) !== 64'h0C01) begin
            tests_failed++; $display("FAIL dr8_tms: got %h want 0c01", seq_tms(rb, 13)); end
        tests_run++; if (seq_tdi(rb, 13) !== 64'h0528) begin
            tests_failed++; $display("FAIL dr8_tdi: got %h want 0528", seq_tdi(rb, 13)); end
        tests_run++; if (bad_intervals(rb, 13) !== 0) begin
            tests_failed++; $display("FAIL dr8_tck_period: got %0d bad want 0", bad_intervals(rb, 13)); end
        tests_run++; if (hi_total - hb !== 13 * CLK_DIV) begin
            tests_failed++; $display("FAIL dr8_tck_high: got %0d want %0d", hi_total - hb, 13 * CLK_DIV); end
        tests_run++; if (valid_total - vb !== 1) begin
            tests_failed++; $display("FAIL dr8_valid_pulses: got %0d want 1", valid_total - vb); end
        tests_run++; if (last_rsp !== 32'h0000_004B) begin
            tests_failed++; $display("FAIL dr8_rsp_at_valid: got %h want 0000004b", last_rsp); end
        tests_run++; if (rsp_data_o !== 32'h0000_004B) begin
            tests_failed++; $display("FAIL dr8_rsp_hold: got %h want 0000004b", rsp_data_o); end
        tests_run++; if (accept_total - ab !== 1) begin
            tests_failed++; $display("FAIL dr8_accepts: got %0d want 1", accept_total - ab); end
    endtask

    task automatic test_idle_hold;
        int rb, vb, ab;
        bit ok;
        tdo_mode = 1;
        rb = rises; vb = valid_total; ab = accept_total;
        cmd_op_i    = 2'b11;
        cmd_len_i   = 5'd2;
        cmd_data_i  = 32'hFFFF_FFFF;
        cmd_valid_i = 1'b1;
        wait_ready(200, ok);
        cmd_valid_i = 1'b0;
        tests_run++; if (ok !== 1'b1) begin
            tests_failed++; $display("FAIL idle_timeout: got %b want 1", ok); end
        tests_run++; if (accept_total - ab !== 1) begin
            tests_failed++; $display("FAIL idle_accepts: got %0d want 1", accept_total - ab); end
        tests_run++; if (rises - rb !== 3) begin
            tests_failed++; $display("FAIL idle_bits: got %0d want 3", rises - rb); end
        tests_run++; if ({seq_tms(rb, 3), seq_tdi(rb, 3)} !== 128'd0) begin
            tests_failed++; $display("FAIL idle_tms_tdi: got %h/%h want 0/0", seq_tms(rb, 3), seq_tdi(rb, 3)); end
        tests_run++; if (valid_total - vb !== 0) begin
            tests_failed++; $display("FAIL idle_no_rsp: got %0d want 0", valid_total - vb); end
        tests_run++; if (rsp_data_o !== 32'h0000_004B) begin
            tests_failed++; $display("FAIL idle_rsp_hold: got %h want 0000004b", rsp_data_o); end
        repeat (20) @(posedge clk_i);
        #1;
        tests_run++; if (rises - rb !== 3 || cmd_ready_o !== 1'b1) begin
            tests_failed++; $display("FAIL idle_not_queued: got %0d bits ready %b want 3 bits ready 1", rises - rb, cmd_ready_o); end
    endtask

    task automatic test_dr_full;
        int rb, hb, vb;
        bit ok;
        tdo_mode = 1;
        rb = rises; hb = hi_total; vb = valid_total;
        issue(2'b10, 5'd31, 32'hDEAD_BEEF);
        wait_ready(400, ok);
        tests_run++; if (ok !== 1'b1) begin
            tests_failed++; $display("FAIL dr32_timeout: got %b want 1", ok); end
        tests_run++; if (rises - rb !== 37) begin
            tests_failed++; $display("FAIL dr32_bits: got %0d want 37", rises - rb); end
        tests_run++; if (seq_tms(rb, 37) !== 64'h0000_000C_0000_0001) begin
            tests_failed++; $display("FAIL dr32_tms: got %h want c00000001", seq_tms(rb, 37)); end
        tests_run++; if (seq_tdi(rb, 37) !== 64'h0000_0006_F56D_F778) begin
            tests_failed++; $display("FAIL dr32_tdi: got %h want 6f56df778", seq_tdi(rb, 37)); end
        tests_run++; if (hi_total - hb !== 37 * CLK_DIV) begin
            tests_failed++; $display("FAIL dr32_tck_high: got %0d want %0d", hi_total - hb, 37 * CLK_DIV); end
        tests_run++; if (valid_total - vb !== 1 || rsp_data_o !== 32'hDEAD_BEEF) begin
            tests_failed++; $display("FAIL dr32_rsp: got %0d pulses data %h want 1 pulses data deadbeef", valid_total - vb, rsp_data_o); end
    endtask

    task automatic test_ir;
        int rb, vb;
        bit ok;
        tdo_mode = 3;
        rb = rises; vb = valid_total;
        issue(2'b01, 5'd4, 32'h0000_001F);
        wait_ready(400, ok);
        tests_run++; if (ok !== 1'b1) begin
            tests_failed++; $display("FAIL ir5_timeout: got %b want 1", ok); end
        tests_run++; if (rises - rb !== 11) begin
            tests_failed++; $display("FAIL ir5_bits: got %0d want 11", rises - rb); end
        tests_run++; if (seq_tms(rb, 11) !== 64'h0303) begin
            tests_failed++; $display("FAIL ir5_tms: got %h want 0303", seq_tms(rb, 11)); end
        tests_run++; if (seq_tdi(rb, 11) !== 64'h01F0) begin
            tests_failed++; $display("FAIL ir5_tdi: got %h want 01f0", seq_tdi(rb, 11)); end
        tests_run++; if (rsp_data_o[31:5] !== 27'd0) begin
            tests_failed++; $display("FAIL ir5_upper_zero: got %h want 0", rsp_data_o[31:5]); end
        tests_run++; if (valid_total - vb !== 1 || rsp_data_o !== 32'h0000_001F) begin
            tests_failed++; $display("FAIL ir5_rsp: got %0d pulses data %h want 1 pulses data 0000001f", valid_total - vb, rsp_data_o); end
    endtask

    task automatic test_abort;
        int rb, vb, rb2;
        bit ok;
        tdo_mode = 1;
        rb = rises; vb = valid_total;
        issue(2'b10, 5'd31, 32'h1234_5678);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_i); #1;
            if (rises - rb >= 14) begin
                ok = 1'b1;
                break;
            end
        end
        tests_run++; if (ok !== 1'b1 || {jtag_tck_o, jtag_tms_o, jtag_tdi_o} !== 3'b101) begin
            tests_failed++; $display("FAIL abort_shift10_pins: got reached %b pins %b want reached 1 pins 101", ok, {jtag_tck_o, jtag_tms_o, jtag_tdi_o}); end
        #2 rst_ni = 1'b0;
        #1;
        tests_run++; if ({jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no, cmd_ready_o, rsp_valid_o} !== 6'b010000) begin
            tests_failed++; $display("FAIL abort_reset_pins: got %b want 010000", {jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no, cmd_ready_o, rsp_valid_o}); end
        tests_run++; if (rsp_data_o !== 32'd0) begin
            tests_failed++; $display("FAIL abort_reset_rsp: got %h want 0", rsp_data_o); end
        repeat (3) @(posedge clk_i);
        #1;
        rb2 = rises;
        rst_ni = 1'b1;
        wait_ready(200, ok);
        tests_run++; if (ok !== 1'b1 || rises - rb2 !== 6) begin
            tests_failed++; $display("FAIL abort_reinit: got ready %b bits %0d want ready 1 bits 6", ok, rises - rb2); end
        tests_run++; if (seq_tms(rb2, 6) !== 64'h1F) begin
            tests_failed++; $display("FAIL abort_reinit_tms: got %h want 1f", seq_tms(rb2, 6)); end
        tests_run++; if (valid_total - vb !== 0) begin
            tests_failed++; $display("FAIL abort_no_rsp: got %0d want 0", valid_total - vb); end
    endtask

    initial begin
        test_reset;
        test_dr_delay;
        test_idle_hold;
        test_dr_full;
        test_ir;
        test_abort;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/jtag_driver.md
JTAG_DRIVER -- requirements
Module: jtag_driver

Interface
REQ-001 SHALL have parameter ClkDiv, default 2: TCK half-period in clk_i cycles, legal range 1..255.
REQ-002 SHALL have port clk_i, input, 1: single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port cmd_valid_i, input, 1: command request.
REQ-005 SHALL have port cmd_ready_o, output, 1: block can accept a command.
REQ-006 SHALL have port cmd_op_i, input, 2: 00 TAP reset, 01 IR scan, 10 DR scan, 11 idle clocks.
REQ-007 SHALL have port cmd_len_i, input, 5: scan length or idle-clock count minus one (1..32).
REQ-008 SHALL have port cmd_data_i, input, 32: TDI data, LSB shifted first.
REQ-009 SHALL have port rsp_valid_o, output, 1: one-cycle pulse, scan result valid.
REQ-010 SHALL have port rsp_data_o, output, 32: captured TDO bits.
REQ-011 SHALL have port jtag_tck_o, output, 1: test clock.
REQ-012 SHALL have port jtag_tms_o, output, 1: test mode select.
REQ-013 SHALL have port jtag_tdi_o, output, 1: test data in.
REQ-014 SHALL have port jtag_trst_no, output, 1: test reset, active-low.
REQ-015 SHALL have port jtag_tdo_i, input, 1: test data out from target; already synchronous to clk_i.

Function
REQ-016 A command SHALL be accepted on a cycle where cmd_valid_i and cmd_ready_o are both 1; op, len and data SHALL be registered on that cycle.
REQ-017 cmd_ready_o SHALL be 1 only in state IDLE; it is 0 for the whole execution of a command.
REQ-018 The FSM SHALL have states INIT, IDLE, RUN and DONE; transitions are INIT->IDLE, IDLE->RUN on accept, RUN->DONE after the last TCK bit, and DONE->IDLE after one cycle.
REQ-019 Each TCK bit SHALL last 2*ClkDiv clk_i cycles: TCK low for ClkDiv cycles, then high for ClkDiv cycles; TCK idles low.
REQ-020 TMS and TDI SHALL change only at the start of a TCK-low phase; TDO SHALL be sampled on the clk_i cycle where TCK rises.
REQ-021 A TAP reset SHALL drive TMS pattern 1,1,1,1,1,0, six bits; jtag_trst_no SHALL be 0 during the first five bits.
REQ-022 A DR scan SHALL drive TMS pattern 1,0,0 (SelectDR, Capture, Shift), then N shift bits with TMS=0 except TMS=1 on the last bit, then 1,0 (Update, Idle).
REQ-023 An IR scan SHALL match a DR scan except that the prefix is 1,1,0,0.
REQ-024 Idle clocks SHALL drive N bits with TMS=0; TDI SHALL be 0 for this op; no response is produced.
REQ-025 N SHALL equal cmd_len_i+1; the bit count SHALL use a 6-bit counter so that N=32 does not wrap.
REQ-026 During the shift bits, TDI SHALL equal cmd_data_i[k] on shift bit k; outside the shift bits TDI SHALL be 0.
REQ-027 TDO sampled on shift bit k SHALL land in rsp_data_o[k]; bits N..31 of rsp_data_o SHALL be 0.
REQ-028 For IR and DR scans, rsp_valid_o SHALL pulse in DONE; there is no backpressure.
REQ-029 rsp_data_o SHALL hold its value until the next scan completes.
REQ-030 A command presented while cmd_ready_o=0 SHALL be ignored and not queued.
REQ-031 Sampling for a bit and the TMS update for the next bit SHALL never occur in the same cycle; at ClkDiv=1 they fall on adjacent cycles.

Reset
REQ-032 While rst_ni=0, outputs SHALL be forced immediately to: tck 0, tms 1, tdi 0, trst_no 0, cmd_ready 0, rsp_valid 0, rsp_data 0.
REQ-033 After rst_ni releases, the block SHALL enter INIT and autonomously execute the TAP reset sequence of REQ-021 with no response, then enter IDLE.
REQ-034 Reset asserted mid-command SHALL abort the command with no rsp_valid_o pulse.

Verification
REQ-035 Bench SHALL check: ClkDiv=2, release reset -> 6 TCK periods of 4 clk each, TMS 111110, trst_no low for first 20 clk, then cmd_ready_o=1.
REQ-036 Bench SHALL check: DR scan, len=7, data=0xA5, target loops TDI->TDO with one-bit delay preset 1 -> 13 TCK bits, TDI on shift bits 1,0,1,0,0,1,0,1, rsp_data_o=0x4B, one rsp_valid pulse.
REQ-037 Bench SHALL check: IR scan, len=4, data=0x1F -> TMS 1100 00001 10, rsp bits 31..5 = 0.
REQ-038 Bench SHALL check: DR scan, len=31, data=0xDEADBEEF, loopback without delay -> rsp_data_o=0xDEADBEEF, 37 TCK bits.
REQ-039 Bench SHALL check: idle op, len=2 -> 3 TCK bits with TMS=0 and no rsp_valid; cmd_valid held high during execution -> no second accept until IDLE.
REQ-040 Bench SHALL check: rst_ni pulsed low during shift bit 10 of a DR scan -> outputs return to reset values the same cycle, no rsp_valid, then the INIT sequence runs.
